// File: rtl/ram_bus_ctrl.sv
// ram_bus_ctrl: burst master for the X/Y/P core RAMs. Converts burst requests
// into AB/write/oe/DB cycles with optional modulo addressing. Read beats are
// prefetched one ahead so a ready consumer sees one beat per cycle. Write beats
// are driven for one full cycle so the RAM can latch them on the falling edge.
module ram_bus_ctrl #(
  parameter int datawidth = 24,
  parameter int addrwidth = 16,
  parameter int lenwidth  = 4
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [addrwidth-1:0] req_addr,
  input  logic [lenwidth-1:0]  req_len,
  input  logic [addrwidth-1:0] req_mod,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [datawidth-1:0] wr_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [datawidth-1:0] rd_data,
  output logic                 done,
  output logic [addrwidth-1:0] AB,
  output logic                 write,
  output logic                 oe,
  inout  wire  [datawidth-1:0] DB
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    WR_WAIT = 3'd4,
    TURN    = 3'd5
  } state_t;

  state_t               state_r, state_s;
  logic [addrwidth-1:0] base_r, base_s, mod_r, mod_s, off_r, off_s, ab_r, ab_s;
  logic [lenwidth-1:0]  cnt_r, cnt_s;
  logic [datawidth-1:0] db_r, db_s, rd_data_r, rd_data_s;
  logic                 write_r, write_s, oe_r, oe_s;
  logic                 rd_valid_r, rd_valid_s, done_r, done_s;
  logic                 req_ready_r, req_ready_s, wr_ready_r, wr_ready_s;
  logic [addrwidth-1:0] issue_ab_s, issue_off_s;

  // Offset step: wraps to zero after reaching the modulus-1 value, linear when md is zero.
  function automatic logic [addrwidth-1:0] next_off(input logic [addrwidth-1:0] off,
                                                    input logic [addrwidth-1:0] md);
    logic [addrwidth-1:0] r;
    if ((md != {addrwidth{1'b0}}) && (off == md)) begin
      r = {addrwidth{1'b0}};
    end else begin
      r = off + {{(addrwidth-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

  // off_r always holds the offset of the next beat to put on the bus.
  assign issue_ab_s  = base_r + off_r;
  assign issue_off_s = next_off(off_r, mod_r);

  // The bus is only ever driven while a write beat is on it; oe and write are exclusive.
  assign DB        = write_r ? db_r : {datawidth{1'bz}};
  assign AB        = ab_r;
  assign write     = write_r;
  assign oe        = oe_r;
  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;
  assign done      = done_r;
  assign req_ready = req_ready_r;
  assign wr_ready  = wr_ready_r;

  // Next-state and next-output logic for the burst sequencer.
  always_comb begin
    state_s    = state_r;
    base_s     = base_r;
    mod_s      = mod_r;
    off_s      = off_r;
    cnt_s      = cnt_r;
    ab_s       = ab_r;
    write_s    = write_r;
    oe_s       = oe_r;
    db_s       = db_r;
    rd_data_s  = rd_data_r;
    rd_valid_s = rd_valid_r;
    done_s     = 1'b0;
    case (state_r)
      IDLE: begin
        write_s = 1'b0;
        oe_s    = 1'b0;
        if (req_valid) begin
          base_s = req_addr;
          mod_s  = req_mod;
          cnt_s  = req_len;
          if (req_write) begin
            off_s   = {addrwidth{1'b0}};
            state_s = WR_WAIT;
          end else begin
            // First read beat goes out immediately; offset 0 is always followed by 1.
            ab_s    = req_addr;
            oe_s    = 1'b1;
            off_s   = {{(addrwidth-1){1'b0}}, 1'b1};
            state_s = RD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RD: begin
        rd_data_s  = DB;
        rd_valid_s = 1'b1;
        state_s    = RD_WAIT;
        if (cnt_r != {lenwidth{1'b0}}) begin
          ab_s  = issue_ab_s;
          off_s = issue_off_s;
          cnt_s = cnt_r - {{(lenwidth-1){1'b0}}, 1'b1};
        end else begin
          oe_s = 1'b0;
        end
      end
      RD_WAIT: begin
        if (rd_ready) begin
          if (oe_r) begin
            // Handshake frees the output register: capture the prefetched beat.
            rd_data_s = DB;
            if (cnt_r != {lenwidth{1'b0}}) begin
              ab_s  = issue_ab_s;
              off_s = issue_off_s;
              cnt_s = cnt_r - {{(lenwidth-1){1'b0}}, 1'b1};
            end else begin
              oe_s = 1'b0;
            end
          end else begin
            rd_valid_s = 1'b0;
            done_s     = 1'b1;
            state_s    = IDLE;
          end
        end else begin
          state_s = RD_WAIT;
        end
      end
      WR_WAIT: begin
        if (wr_valid) begin
          ab_s    = issue_ab_s;
          off_s   = issue_off_s;
          write_s = 1'b1;
          db_s    = wr_data;
          state_s = WR;
        end else begin
          write_s = 1'b0;
        end
      end
      WR: begin
        if (cnt_r == {lenwidth{1'b0}}) begin
          write_s = 1'b0;
          state_s = TURN;
        end else begin
          cnt_s = cnt_r - {{(lenwidth-1){1'b0}}, 1'b1};
          if (wr_valid) begin
            ab_s    = issue_ab_s;
            off_s   = issue_off_s;
            write_s = 1'b1;
            db_s    = wr_data;
          end else begin
            write_s = 1'b0;
            state_s = WR_WAIT;
          end
        end
      end
      TURN: begin
        write_s = 1'b0;
        done_s  = 1'b1;
        state_s = IDLE;
      end
      default: begin
        write_s = 1'b0;
        oe_s    = 1'b0;
        state_s = IDLE;
      end
    endcase
    req_ready_s = (state_s == IDLE);
    wr_ready_s  = (state_s == WR_WAIT) || ((state_s == WR) && (cnt_s != {lenwidth{1'b0}}));
  end

  // State and output registers; reset drops any in-flight beat and frees the bus.
  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_r     <= IDLE;
      base_r      <= {addrwidth{1'b0}};
      mod_r       <= {addrwidth{1'b0}};
      off_r       <= {addrwidth{1'b0}};
      cnt_r       <= {lenwidth{1'b0}};
      ab_r        <= {addrwidth{1'b0}};
      write_r     <= 1'b0;
      oe_r        <= 1'b0;
      db_r        <= {datawidth{1'b0}};
      rd_data_r   <= {datawidth{1'b0}};
      rd_valid_r  <= 1'b0;
      done_r      <= 1'b0;
      req_ready_r <= 1'b1;
      wr_ready_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      base_r      <= base_s;
      mod_r       <= mod_s;
      off_r       <= off_s;
      cnt_r       <= cnt_s;
      ab_r        <= ab_s;
      write_r     <= write_s;
      oe_r        <= oe_s;
      db_r        <= db_s;
      rd_data_r   <= rd_data_s;
      rd_valid_r  <= rd_valid_s;
      done_r      <= done_s;
      req_ready_r <= req_ready_s;
      wr_ready_r  <= wr_ready_s;
    end
  end

endmodule

// File: tb/tb_ram_bus_ctrl.sv
// Bench for ram_bus_ctrl: a RAM model on the shared bus, a reference memory,
// and a negedge monitor that pops expected write cycles / read beats.
module tb_ram_bus_ctrl;
  localparam int DW = 24, AW = 16, LW = 4;

  logic Clk = 1'b0, reset = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0;
  logic [AW-1:0] req_addr = '0, req_mod = '0;
  logic [LW-1:0] req_len = '0;
  logic [DW-1:0] wr_data = '0;
  logic req_ready, wr_ready, rd_valid, done, write, oe;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] AB;
  wire  [DW-1:0] DB;

  ram_bus_ctrl dut (
    .Clk(Clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len), .req_mod(req_mod),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .done(done),
    .AB(AB), .write(write), .oe(oe), .DB(DB)
  );

  always #5 Clk = ~Clk;

  // RAM model: asynchronous read while oe, write latched on the falling edge.
  logic [DW-1:0] ram [0:65535];
  assign DB = (oe && !write) ? ram[AB] : {DW{1'bz}};
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = '0;
    forever begin
      @(negedge Clk);
      if (write) ram[AB] = DB;
    end
  end

  int total = 0, bad = 0, oe_cycles = 0;
  bit busy = 1'b0;
  logic [DW-1:0] ref_mem [int];
  logic [AW-1:0] exp_wa_q[$];
  logic [DW-1:0] exp_wd_q[$];
  logic [DW-1:0] exp_rd_q[$];
  logic [DW-1:0] wd [16];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] beat_addr(logic [AW-1:0] a, logic [AW-1:0] m, int k);
    int off;
    off = (m == '0) ? k : (k % (int'(m) + 1));
    return AW'(int'(a) + off);
  endfunction

  function automatic logic [DW-1:0] ref_rd(logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  // Monitor: compares every bus write and every read handshake against the queues.
  always @(negedge Clk) begin
    if (oe) oe_cycles++;
    if (write) begin
      chk("no_oe_while_write", {31'b0, oe}, 32'd0);
      if (exp_wa_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got AB=%0h DB=%0h expected none", AB, DB);
      end else begin
        chk("wr_addr", {16'b0, AB}, {16'b0, exp_wa_q.pop_front()});
        chk("wr_data", {8'b0, DB}, {8'b0, exp_wd_q.pop_front()});
      end
    end
    if (rd_valid && rd_ready) begin
      if (exp_rd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_read: got %0h expected none", rd_data);
      end else begin
        chk("rd_data", {8'b0, rd_data}, {8'b0, exp_rd_q.pop_front()});
      end
    end
    if (busy) chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
  end

  task automatic idle_checks(string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd1);
    chk({tag, "_wr_ready"}, {31'b0, wr_ready}, 32'd0);
    chk({tag, "_rd_valid"}, {31'b0, rd_valid}, 32'd0);
    chk({tag, "_done"}, {31'b0, done}, 32'd0);
    chk({tag, "_AB"}, {16'b0, AB}, 32'd0);
    chk({tag, "_write"}, {31'b0, write}, 32'd0);
    chk({tag, "_oe"}, {31'b0, oe}, 32'd0);
  endtask

  task automatic issue_req(bit wr, logic [AW-1:0] a, logic [LW-1:0] l, logic [AW-1:0] m, bit hold);
    int t = 0;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = l; req_mod = m;
    while (!req_ready && t < 50) begin @(posedge Clk); #1; t++; end
    chk("req_accept", (t < 50) ? 32'd1 : 32'd0, 32'd1);
    @(posedge Clk); #1;
    busy = 1'b1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic end_burst();
    chk("done_seen", {31'b0, done}, 32'd1);
    req_valid = 1'b0;
    busy = 1'b0;
    chk("req_ready_at_done", {31'b0, req_ready}, 32'd1);
    @(posedge Clk); #1;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("wq_left", exp_wa_q.size(), 32'd0);
    chk("rq_left", exp_rd_q.size(), 32'd0);
  endtask

  // abort_at > 0: assert reset in the WR cycle of that beat.
  task automatic write_burst(logic [AW-1:0] a, logic [LW-1:0] l, logic [AW-1:0] m,
                             bit gaps, int abort_at, bit hold);
    int n = int'(l) + 1;
    int t;
    issue_req(1'b1, a, l, m, hold);
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        wr_valid = 1'b0; @(posedge Clk); #1;
      end
      wr_valid = 1'b1; wr_data = wd[k];
      exp_wa_q.push_back(beat_addr(a, m, k));
      exp_wd_q.push_back(wd[k]);
      ref_mem[int'(beat_addr(a, m, k))] = wd[k];
      t = 0;
      while (!wr_ready && t < 50) begin @(posedge Clk); #1; t++; end
      chk("wr_accept", (t < 50) ? 32'd1 : 32'd0, 32'd1);
      @(posedge Clk); #1;
      if (abort_at == k + 1) begin
        wr_data = 24'h0BAD00;
        reset = 1'b0;
        @(posedge Clk); #1;
        idle_checks("abort");
        reset = 1'b1; wr_valid = 1'b0; req_valid = 1'b0; busy = 1'b0;
        return;
      end
    end
    wr_valid = 1'b0;
    t = 0;
    while (!done && t < 20) begin @(posedge Clk); #1; t++; end
    chk("wr_done_latency", t, 32'd2);
    end_burst();
  endtask

  // mode 0: always ready, 1: random ready, 2: stall second beat 3 cycles.
  task automatic read_burst(logic [AW-1:0] a, logic [LW-1:0] l, logic [AW-1:0] m, int mode);
    int n = int'(l) + 1;
    int t = 0, hs = 0, stalls = 0, oe0;
    for (int k = 0; k < n; k++) exp_rd_q.push_back(ref_rd(beat_addr(a, m, k)));
    oe0 = oe_cycles;
    issue_req(1'b0, a, l, m, 1'b0);
    while (!done && t < 200) begin
      if (mode == 0) rd_ready = 1'b1;
      else if (mode == 1) rd_ready = 1'($urandom_range(0, 1));
      else if (rd_valid && hs == 1 && stalls < 3) begin
        rd_ready = 1'b0; stalls++;
        chk("stall_oe", {31'b0, oe}, 32'd1);
        chk("stall_data", {8'b0, rd_data}, {8'b0, ref_rd(beat_addr(a, m, 1))});
      end else rd_ready = 1'b1;
      if (rd_valid && rd_ready) hs++;
      @(posedge Clk); #1; t++;
    end
    rd_ready = 1'b0;
    chk("rd_handshakes", hs, n);
    if (mode == 0) chk("oe_cycles", oe_cycles - oe0, n);
    if (mode == 2) chk("stall_cycles", stalls, 32'd3);
    end_burst();
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    idle_checks("reset");
    chk("reset_rd_data", {8'b0, rd_data}, 32'd0);
    reset = 1'b1;
    @(posedge Clk); #1;

    for (int k = 0; k < 4; k++) wd[k] = DW'(k + 1);
    write_burst(16'h0010, 4'd3, 16'h0000, 1'b0, 0, 1'b0);
    read_burst(16'h0010, 4'd3, 16'h0000, 0);

    for (int k = 0; k < 6; k++) wd[k] = DW'(k + 1);
    write_burst(16'h0020, 4'd5, 16'h0003, 1'b0, 0, 1'b0);
    read_burst(16'h0020, 4'd3, 16'h0000, 0);

    read_burst(16'h0010, 4'd2, 16'h0000, 2);

    for (int k = 0; k < 4; k++) wd[k] = DW'(24'hA0 + k);
    write_burst(16'h0040, 4'd3, 16'h0000, 1'b0, 0, 1'b0);
    for (int k = 0; k < 4; k++) wd[k] = DW'(24'hE0 + k);
    write_burst(16'h0040, 4'd3, 16'h0000, 1'b0, 2, 1'b0);
    @(posedge Clk); #1;
    read_burst(16'h0040, 4'd3, 16'h0000, 0);

    wd[0] = 24'h123456; wd[1] = 24'h654321;
    write_burst(16'hFFFF, 4'd1, 16'h0000, 1'b0, 0, 1'b1);
    read_burst(16'hFFFF, 4'd1, 16'h0000, 0);

    for (int k = 0; k < 16; k++) wd[k] = DW'($urandom());
    write_burst(16'h0100, 4'd15, 16'h0000, 1'b1, 0, 1'b0);
    read_burst(16'h0100, 4'd15, 16'h0000, 1);

    for (int r = 0; r < 4; r++) begin
      logic [AW-1:0] a, m;
      logic [LW-1:0] l;
      a = AW'($urandom());
      l = LW'($urandom());
      m = ($urandom_range(0, 1) == 0) ? 16'h0000 : AW'($urandom_range(1, 6));
      for (int k = 0; k < 16; k++) wd[k] = DW'($urandom());
      write_burst(a, l, m, 1'b1, 0, 1'b0);
      read_burst(a, l, m, 1);
      read_burst(a, l, 16'h0000, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
